// File: rtl/axi_slv_mem.sv
// AXI4 memory slave: independent single-outstanding write and read engines over a word array.
// Build option AXI_SLV_MEM_RANGE_CHECK_EN: out-of-range beats are dropped/read as zero with SLVERR.
module axi_slv_mem #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic [2:0]              AWPROT,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [ID_WIDTH-1:0]     WID,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic [2:0]              ARPROT,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [ID_WIDTH-1:0]     RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic [1:0]              w_state_dbg,
  output logic                    r_state_dbg
);

  localparam int BYTES   = DATA_WIDTH / 8;
  localparam int BYTE_SH = $clog2(BYTES);
  localparam int IDX_W   = $clog2(MEM_DEPTH);
  localparam int LW      = ADDR_WIDTH + 16;

`ifdef AXI_SLV_MEM_RANGE_CHECK_EN
  localparam logic RANGE_EN = 1'b1;
`else
  localparam logic RANGE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  // Valid/ready: a beat transfers on a rising edge where both are high; a raised
  // VALID and its payload are held unchanged until that edge.

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic unused_ok;
  assign unused_ok = ^{AWPROT, WID, ARPROT};

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  function automatic logic hdr_err(input logic [7:0] len, input logic [2:0] size,
                                   input logic [1:0] burst);
    return (burst == 2'b11) || (32'(size) > BYTE_SH) ||
           ((burst == 2'b10) && !wrap_len_ok(len));
  endfunction

  // An illegal WRAP length and the reserved burst code both walk the address as INCR.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [7:0] len,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] mask;
    step = ADDR_WIDTH'(1) << size;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    if (burst == 2'b00) return addr;
    if ((burst == 2'b10) && wrap_len_ok(len)) return (addr & ~mask) | ((addr + step) & mask);
    return addr + step;
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >> BYTE_SH) < ADDR_WIDTH'(MEM_DEPTH);
  endfunction

  function automatic logic [IDX_W-1:0] midx(input logic [ADDR_WIDTH-1:0] addr);
    return IDX_W'(addr >> BYTE_SH);
  endfunction

  // Reads report range errors on every beat, so the highest address of the whole burst is checked up front.
  function automatic logic burst_oor(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
    logic [LW-1:0] a;
    logic [LW-1:0] span;
    logic [LW-1:0] last;
    a    = LW'(addr);
    span = (LW'(len) + LW'(1)) << size;
    if (burst == 2'b00)                             last = a;
    else if ((burst == 2'b10) && wrap_len_ok(len))  last = (a & ~(span - LW'(1))) + span - LW'(1);
    else                                            last = a + (LW'(len) << size);
    return RANGE_EN && ((last >> BYTE_SH) >= LW'(MEM_DEPTH));
  endfunction

  // ---------------- write engine ----------------
  w_state_t              w_state, w_next;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic [ID_WIDTH-1:0]   w_id;
  logic [8:0]            w_beat;
  logic                  w_err;
  logic                  aw_hs, w_hs, b_hs;
  logic                  w_beat_oor, w_last_bad;

  assign aw_hs       = AWVALID && AWREADY;
  assign w_hs        = WVALID && WREADY;
  assign b_hs        = BVALID && BREADY;
  assign w_state_dbg = w_state;

  always_comb begin
    w_next     = w_state;
    w_beat_oor = RANGE_EN && !in_range(w_addr);
    w_last_bad = (w_beat != {1'b0, w_len});
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && WLAST) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
      BRESP   <= 2'b00;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_id    <= '0;
      w_beat  <= '0;
      w_err   <= 1'b0;
    end else begin
      w_state <= w_next;
      AWREADY <= (w_next == W_IDLE);
      WREADY  <= (w_next == W_DATA);
      BVALID  <= (w_next == W_RESP);
      if (aw_hs) begin
        w_addr  <= AWADDR;
        w_len   <= AWLEN;
        w_size  <= AWSIZE;
        w_burst <= AWBURST;
        w_id    <= AWID;
        w_beat  <= '0;
        w_err   <= hdr_err(AWLEN, AWSIZE, AWBURST);
      end
      if (w_hs) begin
        w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
        if (w_beat != 9'h1FF) w_beat <= w_beat + 9'd1;
        w_err  <= w_err | w_beat_oor;
        if (WLAST) begin
          BID   <= w_id;
          BRESP <= (w_err || w_beat_oor || w_last_bad) ? 2'b10 : 2'b00;
        end
      end
    end
  end

  // Array is deliberately outside the reset domain.
  always_ff @(posedge ACLK) begin
    if (w_hs && !w_beat_oor) begin
      for (int b = 0; b < BYTES; b++) begin
        if (WSTRB[b]) mem[midx(w_addr)][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  r_state_t              r_state, r_next;
  logic [ADDR_WIDTH-1:0] r_addr, r_addr_nx, rd_addr;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [7:0]            r_beat;
  logic                  ar_hs, r_hs;
  logic [DATA_WIDTH-1:0] rd_word;

  assign ar_hs       = ARVALID && ARREADY;
  assign r_hs        = RVALID && RREADY;
  assign r_state_dbg = r_state;

  always_comb begin
    r_next    = r_state;
    r_addr_nx = next_addr(r_addr, r_len, r_size, r_burst);
    rd_addr   = ar_hs ? ARADDR : r_addr_nx;
    rd_word   = (RANGE_EN && !in_range(rd_addr)) ? '0 : mem[midx(rd_addr)];
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && RLAST) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // RDATA is registered so it stays stable while stalled even if the word is rewritten meanwhile.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RID     <= '0;
      RDATA   <= '0;
      RRESP   <= 2'b00;
      RLAST   <= 1'b0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= r_next;
      ARREADY <= (r_next == R_IDLE);
      RVALID  <= (r_next == R_DATA);
      if (ar_hs) begin
        r_addr  <= ARADDR;
        r_len   <= ARLEN;
        r_size  <= ARSIZE;
        r_burst <= ARBURST;
        r_beat  <= '0;
        RID     <= ARID;
        RLAST   <= (ARLEN == 8'd0);
        RRESP   <= (hdr_err(ARLEN, ARSIZE, ARBURST) ||
                    burst_oor(ARADDR, ARLEN, ARSIZE, ARBURST)) ? 2'b10 : 2'b00;
        RDATA   <= rd_word;
      end else if (r_hs && !RLAST) begin
        r_addr <= r_addr_nx;
        r_beat <= r_beat + 8'd1;
        RLAST  <= ((r_beat + 8'd1) == r_len);
        RDATA  <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_axi_slv_mem.sv
// Bench for axi_slv_mem: directed AXI scenarios plus randomized bursts checked against a byte-lane word model.
// Honors AXI_SLV_MEM_RANGE_CHECK_EN when the build defines it.
module tb_axi_slv_mem;

  localparam int IDW   = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;

`ifdef AXI_SLV_MEM_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic           ACLK = 1'b0;
  logic           ARESETn = 1'b0;
  logic [IDW-1:0] AWID = '0, WID = '0, ARID = '0;
  logic [AW-1:0]  AWADDR = '0, ARADDR = '0;
  logic [7:0]     AWLEN = '0, ARLEN = '0;
  logic [2:0]     AWSIZE = '0, ARSIZE = '0, AWPROT = '0, ARPROT = '0;
  logic [1:0]     AWBURST = '0, ARBURST = '0;
  logic           AWVALID = 1'b0, WVALID = 1'b0, WLAST = 1'b0, BREADY = 1'b0;
  logic           ARVALID = 1'b0, RREADY = 1'b0;
  logic [DW-1:0]  WDATA = '0;
  logic [3:0]     WSTRB = '0;
  logic           AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST;
  logic [IDW-1:0] BID, RID;
  logic [1:0]     BRESP, RRESP;
  logic [DW-1:0]  RDATA;
  logic [1:0]     w_state_dbg;
  logic           r_state_dbg;

  axi_slv_mem #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .w_state_dbg(w_state_dbg), .r_state_dbg(r_state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 ACLK = ~ACLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wdata_q[$];
  logic [3:0]    wstrb_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit wrap_ok(input int len);
    return (len == 1) || (len == 3) || (len == 7) || (len == 15);
  endfunction

  function automatic bit hdr_bad(input int len, input int size, input int burst);
    return (burst == 3) || ((1 << size) > DW / 8) || ((burst == 2) && !wrap_ok(len));
  endfunction

  // Byte address of beat i, straight from the burst rules.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input int size,
                                            input int burst, input int i);
    longint unsigned step, total, base;
    step = longint'(1) << size;
    if (burst == 0) return a;
    if ((burst == 2) && wrap_ok(len)) begin
      total = longint'(len + 1) * step;
      base  = longint'(a) - (longint'(a) % total);
      return 32'(base + ((longint'(a) - base) + longint'(i) * step) % total);
    end
    return 32'(longint'(a) + longint'(i) * step);
  endfunction

  function automatic bit oor(input logic [31:0] a);
    return RANGE_EN && ((a >> 2) >= DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  // ---------------- driver tasks ----------------
  // Beats come from wdata_q/wstrb_q; WLAST is raised on beat last_at.
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst, input int last_at);
    int cnt;
    bit err;
    logic [31:0] a;
    err = hdr_bad(len, size, burst) || (last_at != len);
    @(negedge ACLK);
    AWID = id; AWADDR = addr; AWLEN = 8'(len); AWSIZE = 3'(size); AWBURST = 2'(burst);
    AWVALID = 1'b1;
    cnt = 0;
    while (!AWREADY && cnt < 50) begin @(negedge ACLK); cnt++; end
    chk("aw_accept_in_time", 64'(cnt < 50), 64'd1);
    @(negedge ACLK);
    AWVALID = 1'b0;
    chk("aw_ready_drop", 64'(AWREADY), 64'd0);
    for (int i = 0; i <= last_at; i++) begin
      WDATA = wdata_q[i]; WSTRB = wstrb_q[i]; WLAST = (i == last_at); WVALID = 1'b1;
      chk("w_ready", 64'(WREADY), 64'd1);
      a = beat_addr(addr, len, size, burst, i);
      if (oor(a)) err = 1'b1;
      else for (int b = 0; b < 4; b++)
        if (wstrb_q[i][b]) ref_mem[widx(a)][8*b +: 8] = wdata_q[i][8*b +: 8];
      @(negedge ACLK);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    chk("b_valid_rise", 64'(BVALID), 64'd1);
    chk("b_id", 64'(BID), 64'(id));
    chk("b_resp", 64'(BRESP), err ? 64'd2 : 64'd0);
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    chk("b_valid_drop", 64'(BVALID), 64'd0);
    wdata_q.delete();
    wstrb_q.delete();
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input int size, input int burst, input int hold_beat, input int hold_cycles);
    int cnt;
    bit err;
    logic [31:0] a;
    logic [DW-1:0] exp;
    err = hdr_bad(len, size, burst);
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, len, size, burst, i);
      if (oor(a)) begin err = 1'b1; exp_q.push_back('0); end
      else exp_q.push_back(ref_mem[widx(a)]);
    end
    @(negedge ACLK);
    ARID = id; ARADDR = addr; ARLEN = 8'(len); ARSIZE = 3'(size); ARBURST = 2'(burst);
    ARVALID = 1'b1;
    cnt = 0;
    while (!ARREADY && cnt < 50) begin @(negedge ACLK); cnt++; end
    chk("ar_accept_in_time", 64'(cnt < 50), 64'd1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    chk("ar_ready_drop", 64'(ARREADY), 64'd0);
    for (int i = 0; i <= len; i++) begin
      exp = exp_q.pop_front();
      if (i == hold_beat) begin
        for (int h = 0; h < hold_cycles; h++) begin
          chk("r_hold_valid", 64'(RVALID), 64'd1);
          chk("r_hold_data", 64'(RDATA), 64'(exp));
          @(negedge ACLK);
        end
      end
      chk("r_valid", 64'(RVALID), 64'd1);
      chk("r_data", 64'(RDATA), 64'(exp));
      chk("r_resp", 64'(RRESP), err ? 64'd2 : 64'd0);
      chk("r_last", 64'(RLAST), 64'(i == len));
      chk("r_id", 64'(RID), 64'(id));
      RREADY = 1'b1;
      @(negedge ACLK);
      RREADY = 1'b0;
    end
    chk("r_valid_drop", 64'(RVALID), 64'd0);
    chk("ar_ready_back", 64'(ARREADY), 64'd1);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID, RID, RDATA, RRESP, RLAST,
                w_state_dbg, r_state_dbg});
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    int len, size, burst, step;
    logic [31:0] addr;

    repeat (3) @(negedge ACLK);
    chk("reset_outputs_zero", all_outs(), 64'd0);
    ARESETn = 1'b1;

    // Known contents everywhere so any later read has a defined expectation.
    for (int k = 0; k < DEPTH / 256; k++) begin
      for (int i = 0; i < 256; i++) begin wdata_q.push_back($urandom); wstrb_q.push_back(4'hF); end
      do_write(4'(k), 32'(k * 1024), 255, 2, 1, 255);
    end

    // Single INCR write and readback.
    wdata_q.push_back(32'hDEADBEEF); wstrb_q.push_back(4'hF);
    do_write(4'd3, 32'h10, 0, 2, 1, 0);
    do_read(4'd5, 32'h10, 0, 2, 1, -1, 0);

    // INCR burst of four with a stalled beat.
    for (int i = 1; i <= 4; i++) begin wdata_q.push_back(32'(i)); wstrb_q.push_back(4'hF); end
    do_write(4'd1, 32'h100, 3, 2, 1, 3);
    do_read(4'd2, 32'h100, 3, 2, 1, 1, 3);

    // WRAP write, INCR readback from the wrap base.
    for (int i = 0; i < 4; i++) begin wdata_q.push_back(32'hA0 + 32'(i)); wstrb_q.push_back(4'hF); end
    do_write(4'd7, 32'h18, 3, 2, 2, 3);
    do_read(4'd8, 32'h10, 3, 2, 1, -1, 0);
    do_read(4'd9, 32'h18, 3, 2, 2, -1, 0);

    // Byte strobes, then error-coded requests.
    wdata_q.push_back(32'h11223344); wstrb_q.push_back(4'hF);
    do_write(4'd4, 32'h40, 0, 2, 1, 0);
    wdata_q.push_back(32'hAABBCCDD); wstrb_q.push_back(4'b0101);
    do_write(4'd4, 32'h40, 0, 2, 1, 0);
    do_read(4'd4, 32'h40, 0, 2, 1, -1, 0);
    for (int i = 0; i < 2; i++) begin wdata_q.push_back($urandom); wstrb_q.push_back(4'hF); end
    do_write(4'd6, 32'h44, 1, 2, 3, 1);
    for (int i = 0; i < 2; i++) begin wdata_q.push_back($urandom); wstrb_q.push_back(4'hF); end
    do_write(4'd6, 32'h80, 3, 2, 1, 1);
    wdata_q.push_back($urandom); wstrb_q.push_back(4'hF);
    do_write(4'd6, 32'h90, 0, 3, 1, 0);
    for (int i = 0; i < 3; i++) begin wdata_q.push_back($urandom); wstrb_q.push_back(4'hF); end
    do_write(4'd6, 32'hA0, 2, 2, 2, 2);
    do_read(4'd6, 32'h44, 1, 2, 3, -1, 0);
    do_read(4'd6, 32'hA0, 2, 2, 2, -1, 0);

    // Reset in the middle of a four-beat read.
    for (int i = 0; i < 4; i++) begin wdata_q.push_back($urandom); wstrb_q.push_back(4'hF); end
    do_write(4'd2, 32'h200, 3, 2, 1, 3);
    @(negedge ACLK);
    ARID = 4'd9; ARADDR = 32'h200; ARLEN = 8'd3; ARSIZE = 3'd2; ARBURST = 2'd1; ARVALID = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b0;
    chk("rst_beat0", 64'(RDATA), 64'(ref_mem[128]));
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
    chk("rst_beat1", 64'(RDATA), 64'(ref_mem[129]));
    ARESETn = 1'b0;
    #1;
    chk("mid_burst_reset_zero", all_outs(), 64'd0);
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    wdata_q.push_back(32'h0BADF00D); wstrb_q.push_back(4'hF);
    do_write(4'd11, 32'h300, 0, 2, 1, 0);
    do_read(4'd12, 32'h300, 0, 2, 1, -1, 0);

    // Address past the array: aliases word 0 or errors, depending on the build.
    wdata_q.push_back(32'hCAFEF00D); wstrb_q.push_back(4'hF);
    do_write(4'd1, 32'h0, 0, 2, 1, 0);
    do_read(4'd13, 32'h1000, 0, 2, 1, -1, 0);

    // Randomized legal bursts, each read back.
    for (int n = 0; n < 30; n++) begin
      burst = $urandom_range(0, 2);
      size  = $urandom_range(0, 2);
      step  = 1 << size;
      if (burst == 2) begin
        case ($urandom_range(0, 3))
          0: len = 1;
          1: len = 3;
          2: len = 7;
          default: len = 15;
        endcase
      end else len = $urandom_range(0, 7);
      addr = 32'($urandom_range(0, 32'hE00)) & ~32'(step - 1);
      for (int i = 0; i <= len; i++) begin
        wdata_q.push_back($urandom);
        wstrb_q.push_back(4'($urandom_range(0, 15)));
      end
      do_write(4'($urandom_range(0, 15)), addr, len, size, burst, len);
      do_read(4'($urandom_range(0, 15)), addr, len, size, burst,
              $urandom_range(0, len), $urandom_range(0, 2));
    end

    repeat (2) @(negedge ACLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
